// File: rtl/pingpong_buffer_if.sv
// Producer/consumer handshake bundle for pingpong_buffer.
// The master modport is the side that drives strobes and data (producer and consumer engines).
// The slave modport is the buffer itself.
interface pingpong_buffer_if #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned LENGTH_SIZE = 10
);
    localparam int unsigned ADR_SIZE = (LENGTH_SIZE > 1) ? $clog2(LENGTH_SIZE) : 1;

    // Producer side
    logic                 wr_en;
    logic [ADR_SIZE-1:0]  wr_adr;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 wr_done;
    logic                 wr_ready;

    // Consumer side
    logic                 rd_en;
    logic [ADR_SIZE-1:0]  rd_adr;
    logic                 rd_done;
    logic                 rd_ready;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_valid;

    // Status
    logic [1:0]           count;
    logic                 err;

    modport master (
        output wr_en, wr_adr, wr_data, wr_done,
        output rd_en, rd_adr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_valid, count, err
    );

    modport slave (
        input  wr_en, wr_adr, wr_data, wr_done,
        input  rd_en, rd_adr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_valid, count, err
    );
endinterface

// File: rtl/pingpong_buffer.sv
// Double-banked (ping-pong) word buffer for CNN feature-map staging.
// The producer fills one bank while the consumer reads the other.
// Banks swap ownership on accepted wr_done / rd_done handshakes.
// Reads are registered and return data one cycle after the accepted rd_en.
// Optional feature: define PINGPONG_BUFFER_ERR_EN to build the sticky protocol-error flag.
// When that macro is undefined, err is tied low.
module pingpong_buffer #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned LENGTH_SIZE = 10
) (
    input  logic             clk,
    input  logic             rst,
    pingpong_buffer_if.slave bus
);
    localparam int unsigned ADR_SIZE = (LENGTH_SIZE > 1) ? $clog2(LENGTH_SIZE) : 1;
    // One extra bit lets the range compare hold even when the depth is a power of two.
    localparam int unsigned CMP_W    = ADR_SIZE + 1;
    localparam logic [CMP_W-1:0] DEPTH = CMP_W'(LENGTH_SIZE);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    bank_state_t          bank_q [2];
    bank_state_t          bank_d [2];
    logic                 wr_bank_q;
    logic                 wr_bank_d;
    logic                 rd_bank_q;
    logic                 rd_bank_d;
    logic [1:0]           full;

    logic                 wr_ready_c;
    logic                 rd_ready_c;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 wr_handoff;
    logic                 rd_release;

    logic [WORD_SIZE-1:0] mem [2][LENGTH_SIZE];
    logic [WORD_SIZE-1:0] rd_word;
    logic [WORD_SIZE-1:0] rd_data_q;
    logic                 rd_valid_q;

    // Per-bank full flags and the handshake qualifiers derived from them.
    always_comb begin
        full[0]     = (bank_q[0] == BANK_FULL);
        full[1]     = (bank_q[1] == BANK_FULL);
        wr_ready_c  = ~full[wr_bank_q];
        rd_ready_c  = full[rd_bank_q];
        wr_in_range = ({1'b0, bus.wr_adr} < DEPTH);
        rd_in_range = ({1'b0, bus.rd_adr} < DEPTH);
        wr_accept   = bus.wr_en & wr_ready_c & wr_in_range;
        rd_accept   = bus.rd_en & rd_ready_c;
        wr_handoff  = bus.wr_done & wr_ready_c;
        rd_release  = bus.rd_done & rd_ready_c;
    end

    // Bank ownership: a handoff fills the write bank, and a release empties the read bank.
    // When both are accepted they always target different banks, so both apply.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_handoff) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_release) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Bank state and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_bank_q][bus.wr_adr] <= bus.wr_data;
        end
    end

    // Out-of-range reads return zero instead of touching the array.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_bank_q][bus.rd_adr];
        end
    end

    // Registered read port; rd_valid pulses once per accepted read, and data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_word;
            end
        end
    end

`ifdef PINGPONG_BUFFER_ERR_EN
    logic err_q;
    logic err_evt;

    // Any strobe against a bank that is not ready, or an accepted out-of-range access.
    always_comb begin
        err_evt = ((bus.wr_en | bus.wr_done) & ~wr_ready_c)
                | ((bus.rd_en | bus.rd_done) & ~rd_ready_c)
                | (bus.wr_en & wr_ready_c & ~wr_in_range)
                | (bus.rd_en & rd_ready_c & ~rd_in_range);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.wr_ready = wr_ready_c;
    assign bus.rd_ready = rd_ready_c;
    assign bus.count    = {1'b0, full[0]} + {1'b0, full[1]};
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_pingpong_buffer.sv
// Testbench for pingpong_buffer.
// The reference model tracks total handoffs and releases as counters.
// Occupancy is their difference, and each bank index is a counter modulo 2.
module tb_pingpong_buffer;
    localparam int unsigned WS = 32;
    localparam int unsigned LS = 10;
    localparam int unsigned AS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pingpong_buffer_if #(.WORD_SIZE(WS), .LENGTH_SIZE(LS)) bus();

    pingpong_buffer #(.WORD_SIZE(WS), .LENGTH_SIZE(LS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [WS-1:0] m_mem   [2][LS];
    bit            m_known [2][LS];
    int            wr_cnt       = 0;
    int            rd_cnt       = 0;
    logic [WS-1:0] m_data       = '0;
    bit            m_data_known = 1'b1;
    bit            m_valid      = 1'b0;
    bit            m_err        = 1'b0;
    bit            cmp_en       = 1'b0;

    task automatic chk(input string nm, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic model_step();
        int  nf;
        int  wb;
        int  rb;
        bit  wr_ok;
        bit  rd_ok;
        int  wa;
        int  ra;
        if (rst) begin
            wr_cnt       = 0;
            rd_cnt       = 0;
            m_data       = '0;
            m_data_known = 1'b1;
            m_valid      = 1'b0;
            m_err        = 1'b0;
            return;
        end
        nf    = wr_cnt - rd_cnt;
        wr_ok = (nf < 2);
        rd_ok = (nf > 0);
        wb    = wr_cnt % 2;
        rb    = rd_cnt % 2;
        wa    = int'(bus.wr_adr);
        ra    = int'(bus.rd_adr);
        if (bus.wr_en && wr_ok && wa < int'(LS)) begin
            m_mem[wb][wa]   = bus.wr_data;
            m_known[wb][wa] = 1'b1;
        end
        if (bus.rd_en && rd_ok) begin
            m_valid = 1'b1;
            if (ra < int'(LS)) begin
                m_data       = m_mem[rb][ra];
                m_data_known = m_known[rb][ra];
            end else begin
                m_data       = '0;
                m_data_known = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
        end
`ifdef PINGPONG_BUFFER_ERR_EN
        if ((bus.wr_en || bus.wr_done) && !wr_ok) m_err = 1'b1;
        if ((bus.rd_en || bus.rd_done) && !rd_ok) m_err = 1'b1;
        if (bus.wr_en && wr_ok && wa >= int'(LS)) m_err = 1'b1;
        if (bus.rd_en && rd_ok && ra >= int'(LS)) m_err = 1'b1;
`endif
        if (bus.wr_done && wr_ok) wr_cnt++;
        if (bus.rd_done && rd_ok) rd_cnt++;
    endtask

    task automatic compare();
        int nf;
        nf = wr_cnt - rd_cnt;
        chk("wr_ready", WS'(bus.wr_ready), WS'(nf < 2));
        chk("rd_ready", WS'(bus.rd_ready), WS'(nf > 0));
        chk("count",    WS'(bus.count),    WS'(nf));
        chk("rd_valid", WS'(bus.rd_valid), WS'(m_valid));
        chk("err",      WS'(bus.err),      WS'(m_err));
        if (m_data_known) begin
            chk("rd_data", bus.rd_data, m_data);
        end
    endtask

    // Model advances on every clock edge and on reset assertion.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Compare DUT outputs against the model midway through each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) compare();
        end
    end

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_adr  = '0;
        bus.wr_data = '0;
        bus.wr_done = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_adr  = '0;
        bus.rd_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int adr, input logic [WS-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_adr  = AS'(adr);
        bus.wr_data = data;
        tick();
    endtask

    task automatic rd(input int adr);
        bus.rd_en  = 1'b1;
        bus.rd_adr = AS'(adr);
        tick();
    endtask

    // Stimulus: directed sequence first, then random traffic, then reset during a read burst.
    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        chk("rst_wr_ready", WS'(bus.wr_ready), 32'd1);
        chk("rst_rd_ready", WS'(bus.rd_ready), 32'd0);
        chk("rst_count",    WS'(bus.count),    32'd0);
        chk("rst_rd_valid", WS'(bus.rd_valid), 32'd0);
        chk("rst_rd_data",  bus.rd_data,       32'h0);

        // Fill bank 0 and hand it off.
        for (int i = 0; i < int'(LS); i++) wr(i, WS'(32'h11 + i));
        bus.wr_done = 1'b1;
        tick();
        chk("fill0_count",    WS'(bus.count),    32'd1);
        chk("fill0_rd_ready", WS'(bus.rd_ready), 32'd1);
        chk("fill0_wr_ready", WS'(bus.wr_ready), 32'd1);

        rd(3);
        chk("rd3_valid", WS'(bus.rd_valid), 32'd1);
        chk("rd3_data",  bus.rd_data,       32'h14);
        tick();
        chk("rd3_pulse", WS'(bus.rd_valid), 32'd0);

        // Fill bank 1 so both banks are full.
        for (int i = 0; i < int'(LS); i++) wr(i, WS'(32'h21 + i));
        bus.wr_done = 1'b1;
        tick();
        chk("fill1_count",    WS'(bus.count),    32'd2);
        chk("fill1_wr_ready", WS'(bus.wr_ready), 32'd0);

        wr(0, 32'hDEAD);
        rd(0);
        chk("drop_rd_data", bus.rd_data, 32'h11);

        // Both handshakes with both banks full: only the release lands.
        bus.wr_done = 1'b1;
        bus.rd_done = 1'b1;
        tick();
        chk("both_full_count", WS'(bus.count), 32'd1);

        // Both handshakes on different banks: occupancy unchanged.
        bus.wr_done = 1'b1;
        bus.rd_done = 1'b1;
        tick();
        chk("both_ok_count", WS'(bus.count), 32'd1);

        rd(12);
        chk("oor_rd_data",  bus.rd_data,       32'h0);
        chk("oor_rd_valid", WS'(bus.rd_valid), 32'd1);
`ifdef PINGPONG_BUFFER_ERR_EN
        chk("oor_err", WS'(bus.err), 32'd1);
        tick();
        chk("err_sticky", WS'(bus.err), 32'd1);
`else
        chk("oor_err", WS'(bus.err), 32'd0);
        tick();
        chk("err_tied", WS'(bus.err), 32'd0);
`endif

        // Random traffic with the per-cycle compare running.
        for (int n = 0; n < 3000; n++) begin
            bus.wr_en   = ($urandom_range(0, 2) != 0);
            bus.wr_adr  = AS'($urandom_range(0, 11));
            bus.wr_data = WS'($urandom);
            bus.wr_done = ($urandom_range(0, 7) == 0);
            bus.rd_en   = ($urandom_range(0, 1) != 0);
            bus.rd_adr  = AS'($urandom_range(0, 11));
            bus.rd_done = ($urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        // Reset asserted in the middle of a read burst.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.wr_done = 1'b1;
        tick();
        rd(0);
        chk("burst_valid", WS'(bus.rd_valid), 32'd1);
        bus.rd_en  = 1'b1;
        bus.rd_adr = AS'(1);
        @(posedge clk);
        #2;
        chk("burst_valid2", WS'(bus.rd_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rd_valid", WS'(bus.rd_valid), 32'd0);
        chk("async_count",    WS'(bus.count),    32'd0);
        chk("async_rd_ready", WS'(bus.rd_ready), 32'd0);
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
